collatz_stats: RTL and testbench
================================

COLLATZ_STATS -- requirements
Module: collatz_stats

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock, shared with the Collatz controller/datapath.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 bs  in  1  busy flag from the Collatz controller; high for the load cycle plus one cycle per sequence step.
REQ-005 co  in  16  start value presented to the controller; stable while bs=1.
REQ-006 k  in  20  current sequence value from the datapath.
REQ-007 res_rdy  in  1  consumer ready for a result.
REQ-008 res_vld  out  1  result valid.
REQ-009 res_co  out  16  start value of the reported run.
REQ-010 res_stp  out  12  step count of the reported run, saturating.
REQ-011 res_pk  out  20  peak value reached in the reported run.
REQ-012 res_sat  out  1  step count saturated in the reported run.
REQ-013 lost  out  1  sticky flag: a run was dropped because a result was pending.
REQ-014 jobs  out  16  count of results transferred, wrapping.

Function
REQ-015 The block SHALL register bs into bs_q every cycle; a run start is the cycle where bs=1 and bs_q=0.
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 IDLE: on run start, the block SHALL capture co into res_co, set the accumulated step count to 0 and the accumulated peak to co, and go to RUN; otherwise it stays in IDLE.
REQ-018 IDLE entered while bs is already high (mid-run) SHALL NOT start tracking; only a later run start does.
REQ-019 RUN, bs=1: steps SHALL increment by 1, saturating at 4095, and peak SHALL be set to max(peak, k) as a 20-bit unsigned compare.
REQ-020 RUN, steps already 4095 with bs=1: steps SHALL hold at 4095 and the sat flag SHALL be set.
REQ-021 RUN, bs=0: the block SHALL latch steps, peak and sat into res_stp, res_pk and res_sat, and go to DONE.
REQ-022 res_vld SHALL be 1 exactly while in DONE; it rises the cycle after the first bs=0 cycle of a run.
REQ-023 DONE: res_* SHALL hold stable until res_vld and res_rdy are both high at a rising edge.
REQ-024 A transfer SHALL increment jobs by 1, wrapping 65535 to 0.
REQ-025 On transfer without a run start in the same cycle, the block SHALL go to IDLE.
REQ-026 On transfer and run start in the same cycle, the block SHALL go directly to RUN with a fresh capture per REQ-017, and lost SHALL remain unchanged.
REQ-027 A run start in DONE without a transfer SHALL set lost; that run SHALL be ignored entirely and the pending result preserved.
REQ-028 lost SHALL be cleared only by reset.
REQ-029 Peak, steps and sat are run-local: each run start SHALL clear sat and re-seed steps and peak.
REQ-030 res_rdy SHALL be ignored outside DONE.
REQ-031 No output SHALL depend combinationally on res_rdy.

Reset
REQ-032 rst_n=0 at a rising edge SHALL force IDLE and clear bs_q, res_vld, res_co, res_stp, res_pk, res_sat, lost and jobs to 0 on that edge.
REQ-033 A reset mid-run or while a result is pending SHALL discard that run or result.
REQ-034 After reset, a run already in progress (bs=1) SHALL be ignored per REQ-018.

Verification
REQ-035 co=3, bs high for 8 cycles, k sampled 3,10,5,16,8,4,2 -> res_vld=1 the cycle after bs falls, res_stp=7, res_pk=16, res_sat=0, res_co=3.
REQ-036 co=1, bs high for 1 cycle -> res_stp=0, res_pk=1; co=7 (16 steps) -> res_stp=16, res_pk=52.
REQ-037 res_rdy=0 for 5 cycles after res_vld, then a second run starts -> lost=1, the first result is unchanged, and on res_rdy=1 jobs increments by 1 only.
REQ-038 res_rdy=1 in the same cycle as a new run start -> jobs+1, the new run is tracked, and lost stays 0.
REQ-039 bs held high for 4100 cycles -> res_stp=4095 and res_sat=1; the next normal run reports res_sat=0.
REQ-040 rst_n=0 mid-run, then released while bs=1 -> all outputs 0, no result for that run, and the next run is reported correctly.

Source files
------------

// File: rtl/collatz_stats_if.sv
// Result/observation bundle between the Collatz controller/datapath and the stats block.
interface collatz_stats_if;
  logic        bs;
  logic [15:0] co;
  logic [19:0] k;
  logic        res_rdy;
  logic        res_vld;
  logic [15:0] res_co;
  logic [11:0] res_stp;
  logic [19:0] res_pk;
  logic        res_sat;
  logic        lost;
  logic [15:0] jobs;

  modport master (
    output bs, co, k, res_rdy,
    input  res_vld, res_co, res_stp, res_pk, res_sat, lost, jobs
  );

  modport slave (
    input  bs, co, k, res_rdy,
    output res_vld, res_co, res_stp, res_pk, res_sat, lost, jobs
  );
endinterface

// File: rtl/collatz_stats.sv
// Watches a Collatz controller's busy flag and reports start value, step count and peak per run.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for a busy rising edge (a run start)
//   ST_RUN  | accumulating steps/peak while bs=1; bs=0 latches the result
//   ST_DONE | result valid, held until res_rdy; overlapping runs set lost
module collatz_stats (
  input  logic                  clk,
  input  logic                  rst_n,
  collatz_stats_if.slave        s_bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [11:0] STEP_MAX = 12'hFFF;

  state_t      r_state;
  logic        r_bs_q;
  logic        r_armed;
  logic [11:0] r_steps;
  logic [19:0] r_peak;
  logic        r_sat;

  logic        r_res_vld;
  logic [15:0] r_res_co;
  logic [11:0] r_res_stp;
  logic [19:0] r_res_pk;
  logic        r_res_sat;
  logic        r_lost;
  logic [15:0] r_jobs;

  logic        w_start;
  logic        w_xfer;
  logic        w_step_max;
  logic [19:0] w_co_ext;
  logic [19:0] w_peak_nxt;

  // r_armed blocks a "start" seen on the first edge after reset while a run is already under way.
  assign w_start    = s_bus.bs & ~r_bs_q & r_armed;
  assign w_xfer     = (r_state == ST_DONE) & s_bus.res_rdy;
  assign w_step_max = (r_steps == STEP_MAX);
  assign w_co_ext   = {4'd0, s_bus.co};
  assign w_peak_nxt = (s_bus.k > r_peak) ? s_bus.k : r_peak;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bs_q    <= 1'b0;
      r_armed   <= 1'b0;
      r_steps   <= 12'd0;
      r_peak    <= 20'd0;
      r_sat     <= 1'b0;
      r_res_vld <= 1'b0;
      r_res_co  <= 16'd0;
      r_res_stp <= 12'd0;
      r_res_pk  <= 20'd0;
      r_res_sat <= 1'b0;
      r_lost    <= 1'b0;
      r_jobs    <= 16'd0;
    end else begin
      r_bs_q <= s_bus.bs;
      if (!s_bus.bs) begin
        r_armed <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_res_co <= s_bus.co;
            r_steps  <= 12'd0;
            r_peak   <= w_co_ext;
            r_sat    <= 1'b0;
            r_state  <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (s_bus.bs) begin
            if (w_step_max) begin
              r_sat <= 1'b1;
            end else begin
              r_steps <= r_steps + 12'd1;
            end
            r_peak <= w_peak_nxt;
          end else begin
            r_res_stp <= r_steps;
            r_res_pk  <= r_peak;
            r_res_sat <= r_sat;
            r_res_vld <= 1'b1;
            r_state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (w_xfer) begin
            r_jobs    <= r_jobs + 16'd1;
            r_res_vld <= 1'b0;
            if (w_start) begin
              r_res_co <= s_bus.co;
              r_steps  <= 12'd0;
              r_peak   <= w_co_ext;
              r_sat    <= 1'b0;
              r_state  <= ST_RUN;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_start) begin
            // Pending result wins; the overlapping run is dropped entirely.
            r_lost <= 1'b1;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_res_vld <= 1'b0;
        end
      endcase
    end
  end

  assign s_bus.res_vld = r_res_vld;
  assign s_bus.res_co  = r_res_co;
  assign s_bus.res_stp = r_res_stp;
  assign s_bus.res_pk  = r_res_pk;
  assign s_bus.res_sat = r_res_sat;
  assign s_bus.lost    = r_lost;
  assign s_bus.jobs    = r_jobs;

endmodule

// File: tb/tb_collatz_stats.sv
// Directed bench for collatz_stats: hand-computed Collatz runs, backpressure, saturation and reset.
module tb_collatz_stats;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  collatz_stats_if bus ();

  collatz_stats u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [15:0] c);
    bus.bs = 1'b1;
    bus.co = c;
    bus.k  = {4'd0, c};
    tick();
  endtask

  task automatic step(input logic [19:0] kv);
    bus.k = kv;
    tick();
  endtask

  task automatic end_run();
    bus.bs = 1'b0;
    tick();
  endtask

  task automatic xfer();
    bus.res_rdy = 1'b1;
    tick();
    bus.res_rdy = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [15:0] c, input logic [11:0] s,
                         input logic [19:0] p, input logic sat);
    chk({tag, ".vld"}, bus.res_vld, 1);
    chk({tag, ".co"},  bus.res_co,  c);
    chk({tag, ".stp"}, bus.res_stp, s);
    chk({tag, ".pk"},  bus.res_pk,  p);
    chk({tag, ".sat"}, bus.res_sat, sat);
  endtask

  logic [19:0] seq3 [7]  = '{20'd3, 20'd10, 20'd5, 20'd16, 20'd8, 20'd4, 20'd2};
  logic [19:0] seq7 [16] = '{20'd22, 20'd11, 20'd34, 20'd17, 20'd52, 20'd26, 20'd13, 20'd40,
                             20'd20, 20'd10, 20'd5, 20'd16, 20'd8, 20'd4, 20'd2, 20'd1};
  logic [19:0] seq6 [8]  = '{20'd3, 20'd10, 20'd5, 20'd16, 20'd8, 20'd4, 20'd2, 20'd1};

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    bus.bs      = 1'b0;
    bus.co      = 16'd0;
    bus.k       = 20'd0;
    bus.res_rdy = 1'b0;
    tick();
    tick();
    chk("rst.vld",  bus.res_vld, 0);
    chk("rst.co",   bus.res_co,  0);
    chk("rst.stp",  bus.res_stp, 0);
    chk("rst.pk",   bus.res_pk,  0);
    chk("rst.sat",  bus.res_sat, 0);
    chk("rst.lost", bus.lost,    0);
    chk("rst.jobs", bus.jobs,    0);
    rst_n = 1'b1;
    tick();

    // co=3: 7 steps, peak 16
    start_run(16'd3);
    foreach (seq3[i]) step(seq3[i]);
    chk("c3.vld_early", bus.res_vld, 0);
    end_run();
    chk_res("c3", 16'd3, 12'd7, 20'd16, 1'b0);
    chk("c3.jobs", bus.jobs, 0);
    tick();
    chk("c3.hold_stp", bus.res_stp, 7);
    xfer();
    chk("c3.jobs_x", bus.jobs, 1);
    chk("c3.vld_x",  bus.res_vld, 0);

    // co=1: zero steps
    start_run(16'd1);
    end_run();
    chk_res("c1", 16'd1, 12'd0, 20'd1, 1'b0);
    xfer();

    // co=7: 16 steps, peak 52
    start_run(16'd7);
    foreach (seq7[i]) step(seq7[i]);
    end_run();
    chk_res("c7", 16'd7, 12'd16, 20'd52, 1'b0);
    xfer();
    chk("c7.jobs", bus.jobs, 3);

    // transfer coincident with a new run start
    start_run(16'd5);
    step(20'd16); step(20'd8); step(20'd4); step(20'd2); step(20'd1);
    end_run();
    chk_res("c5", 16'd5, 12'd5, 20'd16, 1'b0);
    bus.bs      = 1'b1;
    bus.co      = 16'd6;
    bus.k       = 20'd6;
    bus.res_rdy = 1'b1;
    tick();
    bus.res_rdy = 1'b0;
    chk("b2b.jobs", bus.jobs,    4);
    chk("b2b.vld",  bus.res_vld, 0);
    chk("b2b.lost", bus.lost,    0);
    chk("b2b.co",   bus.res_co,  6);
    foreach (seq6[i]) step(seq6[i]);
    end_run();
    chk_res("c6", 16'd6, 12'd8, 20'd16, 1'b0);
    chk("c6.lost", bus.lost, 0);
    xfer();
    chk("c6.jobs", bus.jobs, 5);

    // backpressure: second run arrives while result is pending
    start_run(16'd3);
    foreach (seq3[i]) step(seq3[i]);
    end_run();
    repeat (5) tick();
    chk("bp.vld_held", bus.res_vld, 1);
    chk("bp.lost_pre", bus.lost, 0);
    start_run(16'd9);
    chk("bp.lost", bus.lost, 1);
    step(20'd28);
    chk_res("bp", 16'd3, 12'd7, 20'd16, 1'b0);
    bus.res_rdy = 1'b1;
    step(20'd14);
    bus.res_rdy = 1'b0;
    chk("bp.jobs", bus.jobs, 6);
    chk("bp.vld_x", bus.res_vld, 0);
    step(20'd7);
    end_run();
    tick();
    chk("bp.ignored_vld", bus.res_vld, 0);
    chk("bp.jobs_once",   bus.jobs,    6);
    chk("bp.lost_sticky", bus.lost,    1);

    // saturation: bs high 4100 cycles
    start_run(16'd27);
    for (int i = 1; i <= 4099; i++) step(20'(i));
    end_run();
    chk_res("sat", 16'd27, 12'd4095, 20'd4099, 1'b1);
    xfer();
    start_run(16'd2);
    step(20'd1);
    end_run();
    chk_res("post_sat", 16'd2, 12'd1, 20'd2, 1'b0);
    xfer();
    chk("post_sat.jobs", bus.jobs, 8);

    // reset mid-run, released while bs still high
    start_run(16'd3);
    step(20'd3);
    step(20'd10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst.vld",  bus.res_vld, 0);
    chk("mrst.co",   bus.res_co,  0);
    chk("mrst.stp",  bus.res_stp, 0);
    chk("mrst.pk",   bus.res_pk,  0);
    chk("mrst.sat",  bus.res_sat, 0);
    chk("mrst.lost", bus.lost,    0);
    chk("mrst.jobs", bus.jobs,    0);
    step(20'd5);
    step(20'd16);
    end_run();
    tick();
    chk("mrst.no_result", bus.res_vld, 0);
    start_run(16'd3);
    foreach (seq3[i]) step(seq3[i]);
    end_run();
    chk_res("after_rst", 16'd3, 12'd7, 20'd16, 1'b0);
    xfer();
    chk("after_rst.jobs", bus.jobs, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
